// File: rtl/prince_glm_sbox_inv.sv
// Two-share glitch-resistant masked PRINCE inverse S-box (16 share domains, registered before compression).
// Optional mask refresh of the output shares is built when GLM_REFRESH_EN is defined.

// One share domain: every ANF cross-product whose share selection equals DOM.
module prince_glm_sbox_inv_dom #(
  parameter logic [3:0] DOM = 4'h0
) (
  input  logic [3:0] s0_i,
  input  logic [3:0] s1_i,
  output logic [3:0] y_o
);
  // InvS table, entry x at bits [4x+3:4x]
  localparam logic [63:0] INVS = {4'h1, 4'hC, 4'hE, 4'h5, 4'h0, 4'h4, 4'h6, 4'hA,
                                   4'h9, 4'h8, 4'hD, 4'hF, 4'h2, 4'h3, 4'h7, 4'hB};

  // Moebius transform of the truth table of output bit j gives its ANF coefficients
  function automatic logic [15:0] anf(input int j);
    logic [15:0] t;
    for (int x = 0; x < 16; x++) t[x] = INVS[4*x+j];
    for (int i = 0; i < 4; i++)
      for (int x = 0; x < 16; x++)
        if (x[i]) t[x] = t[x] ^ t[x ^ (1 << i)];
    return t;
  endfunction

  localparam logic [3:0][15:0] ANF = {anf(3), anf(2), anf(1), anf(0)};

  logic [3:0] sel;
  logic [3:0] mm;
  logic       p;

  assign sel = (DOM & s1_i) | (~DOM & s0_i);

  // A monomial m contributes here only if DOM selects share 1 on a subset of m's variables
  always_comb begin
    y_o = '0;
    mm  = '0;
    p   = 1'b0;
    for (int j = 0; j < 4; j++) begin
      for (int m = 0; m < 16; m++) begin
        mm = 4'(m);
        if (ANF[j][m] && ((DOM & ~mm) == 4'b0)) begin
          p = 1'b1;
          for (int i = 0; i < 4; i++)
            if (mm[i]) p = p & sel[i];
          y_o[j] = y_o[j] ^ p;
        end
      end
    end
  end
endmodule

module prince_glm_sbox_inv (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
`ifdef GLM_REFRESH_EN
  input  logic [3:0] r,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] b0,
  output logic [3:0] b1
);
  typedef enum logic [1:0] {IDLE, DOM, COMP, HOLD} state_e;

  state_e            state_q, state_d;
  logic [3:0]        s0_q, s1_q;
  logic [15:0][3:0]  dom_d, dom_q;
  logic [3:0]        b0_q, b1_q;
  logic [3:0]        c0, c1;
  logic              accept;

  assign accept = (state_q == IDLE) && in_valid;

  for (genvar g = 0; g < 16; g++) begin : g_dom
    prince_glm_sbox_inv_dom #(.DOM(4'(g))) u_dom (
      .s0_i (s0_q),
      .s1_i (s1_q),
      .y_o  (dom_d[g])
    );
  end

  // Compression sees only registered domain values
  always_comb begin
    c0 = '0;
    c1 = '0;
    for (int d = 0; d < 8; d++) begin
      c0 = c0 ^ dom_q[d];
      c1 = c1 ^ dom_q[d+8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = DOM;
      DOM:                    state_d = COMP;
      COMP:                   state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
  end

`ifdef GLM_REFRESH_EN
  logic [3:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= '0;
    else if (accept) r_q <= r;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q  <= '0;
      s1_q  <= '0;
      dom_q <= '0;
      b0_q  <= '0;
      b1_q  <= '0;
    end else begin
      if (accept) begin
        s0_q <= a0;
        s1_q <= a1;
      end
      if (state_q == DOM) dom_q <= dom_d;
      if (state_q == COMP) begin
`ifdef GLM_REFRESH_EN
        // same mask on both shares leaves the unmasked sum untouched
        b0_q <= c0 ^ r_q;
        b1_q <= c1 ^ r_q;
`else
        b0_q <= c0;
        b1_q <= c1;
`endif
      end
    end
  end

  assign b0 = b0_q;
  assign b1 = b1_q;
endmodule

// File: tb/tb_prince_glm_sbox_inv.sv
// Bench for prince_glm_sbox_inv: table-driven reference model plus directed vectors.
module tb_prince_glm_sbox_inv;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a0 = '0;
  logic [3:0] a1 = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] b0, b1;
`ifdef GLM_REFRESH_EN
  logic [3:0] r = '0;
`endif

  always #5 clk = ~clk;

  prince_glm_sbox_inv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a0        (a0),
    .a1        (a1),
`ifdef GLM_REFRESH_EN
    .r         (r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b0        (b0),
    .b1        (b1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] INVS [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                            4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: one item in flight, output valid from its third cycle on
  logic       m_busy = 1'b0;
  int         m_age  = 0;
  logic [3:0] m_sum  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_sum  <= INVS[a0 ^ a1];
      end
    end else if (m_age >= 2 && out_ready) begin
      m_busy <= 1'b0;
    end else if (m_age < 3) begin
      m_age <= m_age + 1;
    end
  end

  logic [3:0] pb0 = '0, pb1 = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("out_valid", 32'(out_valid), 32'(m_busy && m_age >= 2));
      if (m_busy && m_age >= 2) check("sum", 32'(b0 ^ b1), 32'(m_sum));
      if (m_busy && m_age == 3) begin
        check("hold_b0", 32'(b0), 32'(pb0));
        check("hold_b1", 32'(b1), 32'(pb1));
      end
    end
    pb0 = b0;
    pb1 = b1;
  end

  task automatic txn(input logic [3:0] x0, input logic [3:0] x1,
                     output logic [3:0] y0, output logic [3:0] y1, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    a0        = x0;
    a1        = x1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a0       = 4'($urandom);
    a1       = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("timeout", 32'(out_valid), 32'd1);
    y0 = b0;
    y1 = b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] y0, y1, hb0, hb1, first_b0;
    int         lat;
    logic       varies;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_b0", 32'(b0), 32'd0);
    check("rst_b1", 32'(b1), 32'd0);
    rst_n = 1'b1;

    txn(4'h0, 4'h0, y0, y1, lat);
    check("spot_00", 32'(y0 ^ y1), 32'hB);
    check("latency", 32'(lat), 32'd2);
    txn(4'hF, 4'h0, y0, y1, lat);
    check("spot_F0", 32'(y0 ^ y1), 32'h1);
    txn(4'h5, 4'hA, y0, y1, lat);
    check("spot_5A", 32'(y0 ^ y1), 32'h1);
    txn(4'h3, 4'h3, y0, y1, lat);
    check("spot_33", 32'(y0 ^ y1), 32'hB);

    for (int x0 = 0; x0 < 16; x0++)
      for (int x1 = 0; x1 < 16; x1++) begin
        txn(4'(x0), 4'(x1), y0, y1, lat);
        check("exhaustive", 32'(y0 ^ y1), 32'(INVS[4'(x0) ^ 4'(x1)]));
      end

    varies   = 1'b0;
    first_b0 = '0;
    for (int x = 0; x < 16; x++) begin
      txn(4'(x), 4'(x) ^ 4'h6, y0, y1, lat);
      check("share_indep", 32'(y0 ^ y1), 32'h8);
      if (x == 0) first_b0 = y0;
      else if (y0 != first_b0) varies = 1'b1;
    end
    check("b0_varies", 32'(varies), 32'd1);

    // backpressure with ignored input pulses
    @(negedge clk);
    in_valid = 1'b1; a0 = 4'h3; a1 = 4'h0; out_ready = 1'b0;
    @(negedge clk);
    a0 = 4'h7;
    check("ign_dom_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("ign_comp_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    hb0 = b0;
    hb1 = b1;
    check("bp_sum", 32'(hb0 ^ hb1), 32'h2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_b0_stable", 32'(b0), 32'(hb0));
      check("bp_b1_stable", 32'(b1), 32'(hb1));
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // asynchronous reset in the middle of an item
    @(negedge clk);
    in_valid = 1'b1; a0 = 4'h1; a1 = 4'h0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_b0", 32'(b0), 32'd0);
    check("mid_rst_b1", 32'(b1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(4'h4, 4'h0, y0, y1, lat);
    check("post_rst", 32'(y0 ^ y1), 32'hF);

`ifdef GLM_REFRESH_EN
    r = 4'h9;
    txn(4'h2, 4'h0, y0, y1, lat);
    hb0 = y0;
    check("refresh_sum_r9", 32'(y0 ^ y1), 32'h3);
    r = 4'h0;
    txn(4'h2, 4'h0, y0, y1, lat);
    check("refresh_sum_r0", 32'(y0 ^ y1), 32'h3);
    check("refresh_delta", 32'(hb0 ^ y0), 32'h9);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
